// File: rtl/pipe_result_divider_if.sv
// Valid/ready bundle between the pipeline result producer, the divider and its consumer.
// The slave side is the divider; the master side is whatever feeds and drains it.
interface pipe_result_divider_if #(
  parameter int unsigned DW = 6,
  parameter int unsigned VW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/pipe_result_divider.sv
// Sequential restoring divider, one quotient bit per clock MSB first, one op in flight.
// A zero divisor skips the bit steps and reports all-ones quotient after one cycle.
module pipe_result_divider #(
  parameter int unsigned DW = 6,
  parameter int unsigned VW = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipe_result_divider_if.slave  bus
);
  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [VW-1:0] rem;
  logic [DW-1:0] q_work;
  logic [DW-1:0] dvd;
  logic [VW-1:0] dvs;
  logic          zero_div;

  logic          in_ready_q;
  logic          out_valid_q;
  logic [DW-1:0] quotient_q;
  logic [VW-1:0] remainder_q;
  logic          dbz_q;

  logic [VW:0]   rem_shift_c;
  logic          ge_c;
  logic [VW-1:0] rem_next_c;
  logic [DW-1:0] q_next_c;

  // One restoring step: shift in the next dividend bit, subtract when it fits.
  always_comb begin
    rem_shift_c = {rem, dvd[cnt]};
    ge_c        = (rem_shift_c >= {1'b0, dvs});
    rem_next_c  = ge_c ? VW'(rem_shift_c - {1'b0, dvs}) : rem_shift_c[VW-1:0];
    q_next_c    = q_work;
    q_next_c[cnt] = ge_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      q_work      <= '0;
      dvd         <= '0;
      dvs         <= '0;
      zero_div    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            dvd        <= bus.dividend;
            dvs        <= bus.divisor;
            cnt        <= CW'(DW - 1);
            rem        <= '0;
            q_work     <= '0;
            zero_div   <= (bus.divisor == '0);
            dbz_q      <= 1'b0;
            in_ready_q <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (zero_div) begin
            quotient_q  <= '1;
            remainder_q <= '0;
            dbz_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            rem    <= rem_next_c;
            q_work <= q_next_c;
            cnt    <= cnt - CW'(1);
            if (cnt == '0) begin
              quotient_q  <= q_next_c;
              remainder_q <= rem_next_c;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          // Result holds until the consumer takes it.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_pipe_result_divider.sv
// Directed bench for pipe_result_divider: latency, back-to-back, zero divisor,
// backpressure, async reset mid-operation and operand changes while busy.
module tb_pipe_result_divider;
  localparam int unsigned DW = 6;
  localparam int unsigned VW = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   low;

  pipe_result_divider_if #(.DW(DW), .VW(VW)) bus ();

  pipe_result_divider #(.DW(DW), .VW(VW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input int q, input int r, input int z);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_q"}, 32'(bus.quotient), 32'(q));
    check({tag, "_r"}, 32'(bus.remainder), 32'(r));
    check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(z));
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_q", 32'(bus.quotient), 32'd0);
    check("rst_r", 32'(bus.remainder), 32'd0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    tick();

    // 42/6 with out_ready held high: result at T+6
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.dividend  = 6'd42;
    bus.divisor   = 3'd6;
    tick();
    bus.in_valid = 1'b0;
    check("a_in_ready_low", 32'(bus.in_ready), 32'd0);
    repeat (5) tick();
    check("a_not_early", 32'(bus.out_valid), 32'd0);
    tick();
    check_result("a", 7, 0, 0);
    tick();
    check("a_valid_drop", 32'(bus.out_valid), 32'd0);
    check("a_ready_rise", 32'(bus.in_ready), 32'd1);

    // 63/5 then 5/7 back-to-back, in_valid held high throughout
    bus.in_valid = 1'b1;
    bus.dividend = 6'd63;
    bus.divisor  = 3'd5;
    tick();
    bus.dividend = 6'd5;
    bus.divisor  = 3'd7;
    low = bus.in_ready ? 0 : 1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      low += bus.in_ready ? 0 : 1;
    end
    check_result("b1", 12, 3, 0);
    tick();
    check("b1_ready_low_cycles", 32'(low), 32'(DW + 1));
    check("b1_ready_rise", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("b2_accepted", 32'(bus.in_ready), 32'd0);
    repeat (6) tick();
    check_result("b2", 0, 5, 0);
    tick();

    // 20/0: result one cycle after accept, then 9/2 clears div_by_zero
    bus.in_valid = 1'b1;
    bus.dividend = 6'd20;
    bus.divisor  = 3'd0;
    tick();
    bus.in_valid = 1'b0;
    check("c_not_early", 32'(bus.out_valid), 32'd0);
    tick();
    check_result("c", 63, 0, 1);
    tick();
    check("c_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.dividend = 6'd9;
    bus.divisor  = 3'd2;
    tick();
    bus.in_valid = 1'b0;
    check("d_dbz_cleared", 32'(bus.div_by_zero), 32'd0);
    repeat (6) tick();
    check_result("d", 4, 1, 0);
    tick();

    // 50/7 under backpressure with in_valid kept high
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.dividend  = 6'd50;
    bus.divisor   = 3'd7;
    tick();
    bus.dividend = 6'd9;
    bus.divisor  = 3'd2;
    repeat (6) tick();
    check_result("e", 7, 1, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_result("e_hold", 7, 1, 0);
      check("e_hold_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    tick();
    check("e_release_valid", 32'(bus.out_valid), 32'd0);
    check("e_release_ready", 32'(bus.in_ready), 32'd1);
    check("e_idle_q_hold", 32'(bus.quotient), 32'd7);

    // Asynchronous reset in the middle of a divide
    bus.in_valid = 1'b1;
    bus.dividend = 6'd42;
    bus.divisor  = 3'd6;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("f_rst_ready", 32'(bus.in_ready), 32'd1);
    check("f_rst_valid", 32'(bus.out_valid), 32'd0);
    check("f_rst_q", 32'(bus.quotient), 32'd0);
    check("f_rst_r", 32'(bus.remainder), 32'd0);
    check("f_rst_dbz", 32'(bus.div_by_zero), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.in_valid = 1'b1;
    bus.dividend = 6'd12;
    bus.divisor  = 3'd4;
    tick();
    bus.in_valid = 1'b0;
    repeat (6) tick();
    check_result("g", 3, 0, 0);
    tick();

    // Operands changed while busy must not affect the result (13/3)
    bus.in_valid = 1'b1;
    bus.dividend = 6'd13;
    bus.divisor  = 3'd3;
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.dividend = 6'd0;
    bus.divisor  = 3'd1;
    repeat (5) tick();
    check_result("h", 4, 1, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
